// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: default 640x480@60
// timing, the per-axis phase encoding and a helper that sums an axis period.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Phase of one raster axis, visited strictly in this order.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // Number of counts in one full period of an axis.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with its phase FSM.
// The next-state count and phase are exported so the parent can register
// outputs that describe the position held after the same edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] cnt_nxt,
    output phase_e       phase_nxt,
    output logic         wrap
);

    localparam int unsigned TOTAL  = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W-1:0] B_FP   = W'(ACTIVE);
    localparam logic [W-1:0] B_SYNC = W'(ACTIVE + FP);
    localparam logic [W-1:0] B_BP   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q, cnt_d;
    phase_e       phase_q, phase_d;

    assign wrap      = advance && (cnt_q == LAST);
    assign cnt_nxt   = cnt_d;
    assign phase_nxt = phase_d;

    // Next count and next phase; the phase moves on when the count reaches
    // the first position of the following region.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (advance) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
            unique case (phase_q)
                PH_ACTIVE: if (cnt_d == B_FP)   phase_d = PH_FP;
                PH_FP:     if (cnt_d == B_SYNC) phase_d = PH_SYNC;
                PH_SYNC:   if (cnt_d == B_BP)   phase_d = PH_BP;
                PH_BP:     if (cnt_d == '0)     phase_d = PH_ACTIVE;
            endcase
        end
    end

    // State registers; reset parks the axis on its last position so the
    // first advance lands on position 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= LAST;
            phase_q <= PH_BP;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the display path: sync pulses, data enable,
// pixel coordinates and line/frame start strobes, all registered and decoded
// from the counters' next state so they describe the position after the edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic           CLK_25M,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: every timing parameter must be nonzero");
    end
    if (64'(H_TOTAL) > (64'd1 << X_W)) begin : g_bad_x_w
        $error("vga_timing_gen: H_TOTAL does not fit in X_W bits");
    end
    if (64'(V_TOTAL) > (64'd1 << Y_W)) begin : g_bad_y_w
        $error("vga_timing_gen: V_TOTAL does not fit in Y_W bits");
    end

    logic [X_W-1:0] h_cnt_nxt;
    logic [Y_W-1:0] v_cnt_nxt;
    phase_e         h_phase_nxt, v_phase_nxt;
    logic           h_wrap, v_wrap;
    logic           v_advance;

    // Vertical position only moves when the line wraps.
    assign v_advance = en && h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
    ) u_h_axis (
        .clk      (CLK_25M),
        .rst_n    (rst_n),
        .advance  (en),
        .cnt_nxt  (h_cnt_nxt),
        .phase_nxt(h_phase_nxt),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
    ) u_v_axis (
        .clk      (CLK_25M),
        .rst_n    (rst_n),
        .advance  (v_advance),
        .cnt_nxt  (v_cnt_nxt),
        .phase_nxt(v_phase_nxt),
        .wrap     (v_wrap)
    );

    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic           h_act, v_act;

    // Output decode from the next-state position; a stalled raster holds
    // syncs and x while de and the strobes drop.
    always_comb begin
        h_act         = (h_phase_nxt == PH_ACTIVE);
        v_act         = (v_phase_nxt == PH_ACTIVE);
        hsync_d       = (h_phase_nxt == PH_SYNC) ? HS_POL : !HS_POL;
        vsync_d       = (v_phase_nxt == PH_SYNC) ? VS_POL : !VS_POL;
        de_d          = en && h_act && v_act;
        x_d           = x_q;
        if (en) begin
            x_d = de_d ? h_cnt_nxt : '0;
        end
        y_d           = v_act ? v_cnt_nxt : '0;
        line_start_d  = en && (h_cnt_nxt == '0) && v_act;
        frame_start_d = en && (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
    end

    // Output registers, forced to the idle raster state by reset.
    always_ff @(posedge CLK_25M) begin
        if (!rst_n) begin
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    // The frame wrap is implied by the line wrap and the vertical count.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule
